// File: rtl/dog_writer.sv
// Difference-of-Gaussians writer: streams two same-octave Gaussian images out of
// their BRAMs and writes blur - sharp, signed, into the DoG BRAM at one pixel per cycle.
module dog_writer #(
  parameter int BIT_DEPTH    = 8,
  parameter int DIMENSION    = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_in_n,
  input  logic                        enable,
  input  logic [BIT_DEPTH-1:0]        sharp_data,
  input  logic [BIT_DEPTH-1:0]        blur_data,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] read_address,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] write_address,
  output logic signed [BIT_DEPTH:0]   write_data,
  output logic                        write_enable,
  output logic                        busy,
  output logic                        done
);

  localparam int N  = DIMENSION * DIMENSION;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t state, next_state;

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [AW-1:0]           addr_pipe [READ_LATENCY];
  logic signed [BIT_DEPTH:0] diff;

  // Both operands are zero-extended, so the 9-bit result can never overflow.
  assign diff = $signed({1'b0, blur_data}) - $signed({1'b0, sharp_data});

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) state <= IDLE;
    else           state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (enable) next_state = STREAM;
      STREAM: if (read_address == LAST) next_state = DRAIN;
      DRAIN:  if (write_enable && write_address == LAST) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Termination is detected at LAST, so the counter is reloaded rather than wrapped.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n)                                   read_address <= '0;
    else if (state == STREAM && read_address != LAST) read_address <= read_address + AW'(1);
    else                                             read_address <= '0;
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == STREAM);
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // NOTE: only the valid bits need reset; the address delay line is qualified
  // by them, so it is left unreset and can map onto plain shift registers.
  always_ff @(posedge clk) begin
    addr_pipe[0] <= read_address;
    for (int i = 1; i < READ_LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      write_enable  <= vld_pipe[READ_LATENCY-1];
      write_address <= addr_pipe[READ_LATENCY-1];
      write_data    <= diff;
    end
  end

  assign busy = (state == STREAM) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_dog_writer.sv
// Self-checking bench for dog_writer: three instances (4x4/latency 2, 8x8/latency 1,
// 8x8/latency 3) with BRAM models, a write scoreboard and per-cycle control checks.
module tb_dog_writer;

  localparam int NDUT = 3;

  typedef enum int {PAT_RAMP, PAT_CONST, PAT_MIX} pat_t;
  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct {
    string              name;
    logic [7:0]         blur;
    logic [7:0]         sharp;
    logic signed [8:0]  exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDUT-1:0] en = '0;
  int              edge_cnt = 0;
  pat_t            pat = PAT_RAMP;
  logic [7:0]      cb = 8'd0;
  logic [7:0]      cs = 8'd0;
  int              c_exp = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  vec_t            vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] blur_f(input int a, input pat_t p, input logic [7:0] c);
    case (p)
      PAT_RAMP:  return 8'(a * 16);
      PAT_CONST: return c;
      default:   return 8'(a * 37);
    endcase
  endfunction

  function automatic logic [7:0] sharp_f(input int a, input pat_t p, input logic [7:0] c);
    case (p)
      PAT_RAMP:  return 8'(255 - a * 16);
      PAT_CONST: return c;
      default:   return 8'(a * 91 + 5);
    endcase
  endfunction

  function automatic int exp_f(input int a, input pat_t p, input int ce);
    logic [7:0] b, s;
    b = 8'(a * 37);
    s = 8'(a * 91 + 5);
    case (p)
      PAT_RAMP:  return 32 * a - 255;
      PAT_CONST: return ce;
      default:   return int'(b) - int'(s);
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int DIM = (g == 0) ? 4 : 8;
    localparam int RL  = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    localparam int N   = DIM * DIM;
    localparam int AW  = $clog2(N);

    logic [7:0]        sharp_data, blur_data;
    logic [AW-1:0]     read_address, write_address;
    logic signed [8:0] write_data;
    logic              write_enable, busy, done;
    logic [AW-1:0]     ap [RL];
    wr_t               exp_q [$];
    int                t_start = 0;
    bit                active = 1'b0;
    int                next_ok = 0;
    int                n_writes = 0;
    int                now;
    bit                exp_we;

    dog_writer #(.BIT_DEPTH(8), .DIMENSION(DIM), .READ_LATENCY(RL)) u_dut (
      .clk           (clk),
      .rst_in_n      (rst_n),
      .enable        (en[g]),
      .sharp_data    (sharp_data),
      .blur_data     (blur_data),
      .read_address  (read_address),
      .write_address (write_address),
      .write_data    (write_data),
      .write_enable  (write_enable),
      .busy          (busy),
      .done          (done)
    );

    // BRAM model: data for an address is valid RL cycles after it is presented.
    always @(posedge clk) begin
      ap[0] <= read_address;
      for (int j = 1; j < RL; j++) ap[j] <= ap[j-1];
    end
    assign blur_data  = blur_f(int'(ap[RL-1]), pat, cb);
    assign sharp_data = sharp_f(int'(ap[RL-1]), pat, cs);

    // Reference model: an accepted enable at edge E schedules the whole pass.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_q.delete();
        active  <= 1'b0;
        next_ok <= 0;
      end else if (en[g] && (edge_cnt + 1) >= next_ok) begin
        t_start <= edge_cnt + 1;
        active  <= 1'b1;
        next_ok <= edge_cnt + 1 + N + RL + 3;
        for (int a = 0; a < N; a++)
          exp_q.push_back('{cyc: edge_cnt + 1 + RL + 2 + a, addr: a, data: exp_f(a, pat, c_exp)});
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        now = edge_cnt + 1;
        check($sformatf("dut%0d_busy_c%0d", g, now), busy,
              active && now >= t_start + 1 && now <= t_start + N + RL + 1);
        check($sformatf("dut%0d_done_c%0d", g, now), done,
              active && now == t_start + N + RL + 2);
        check($sformatf("dut%0d_read_address_c%0d", g, now), read_address,
              (active && now >= t_start + 1 && now <= t_start + N) ? now - t_start - 1 : 0);
        exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == now);
        check($sformatf("dut%0d_write_enable_c%0d", g, now), write_enable, exp_we);
        if (write_enable) n_writes++;
        if (exp_we) begin
          if (write_enable) begin
            check($sformatf("dut%0d_write_address_c%0d", g, now), write_address, exp_q[0].addr);
            check($sformatf("dut%0d_write_data_a%0d", g, exp_q[0].addr), $signed(write_data), exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k);
    en[k] = 1'b1;
    tick(1);
    en[k] = 1'b0;
  endtask

  initial begin
    int t0, w0, w1, w2;
    vecs[0] = '{"blur0_sharp255",   8'd0,   8'd255, -9'sd255};
    vecs[1] = '{"blur255_sharp0",   8'd255, 8'd0,    9'sd255};
    vecs[2] = '{"blur128_sharp128", 8'd128, 8'd128,  9'sd0};
    vecs[3] = '{"blur200_sharp13",  8'd200, 8'd13,   9'sd187};
    vecs[4] = '{"blur13_sharp200",  8'd13,  8'd200, -9'sd187};

    // Reset state
    #23;
    check("rst_read_address",  g_dut[0].read_address, 0);
    check("rst_write_address", g_dut[0].write_address, 0);
    check("rst_write_data",    g_dut[0].write_data, 0);
    check("rst_write_enable",  g_dut[0].write_enable, 0);
    check("rst_busy",          g_dut[0].busy, 0);
    check("rst_done",          g_dut[0].done, 0);
    rst_n = 1'b1;
    tick(2);

    // Ramp pass with ignored enables at T+5 and T+20, then enable held from T+21
    pat = PAT_RAMP;
    w0 = g_dut[0].n_writes;
    pulse(0);
    t0 = edge_cnt;
    tick(4);
    en[0] = 1'b1;
    tick(1);
    en[0] = 1'b0;
    tick(14);
    en[0] = 1'b1;
    check("done_cycle_T20_done", g_dut[0].done, 1);
    check("done_cycle_T20_busy", g_dut[0].busy, 0);
    tick(1);
    check("pass1_writes", g_dut[0].n_writes - w0, 16);
    check("pass1_queue_empty", g_dut[0].exp_q.size(), 0);
    tick(1);
    check("restart_edge", edge_cnt, t0 + 21);
    tick(23);
    en[0] = 1'b0;
    tick(30);
    check("three_pass_writes", g_dut[0].n_writes - w0, 48);
    check("three_pass_queue_empty", g_dut[0].exp_q.size(), 0);

    // Arithmetic extremes from the vector table
    for (int i = 0; i < 5; i++) begin
      pat   = PAT_CONST;
      cb    = vecs[i].blur;
      cs    = vecs[i].sharp;
      c_exp = int'(vecs[i].exp);
      w0 = g_dut[0].n_writes;
      pulse(0);
      tick(22);
      check({vecs[i].name, "_writes"}, g_dut[0].n_writes - w0, 16);
      check({vecs[i].name, "_last_data"}, $signed(g_dut[0].write_data), vecs[i].exp);
    end

    // Asynchronous reset in the middle of cycle T+10
    pat = PAT_RAMP;
    pulse(0);
    tick(9);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_read_address",  g_dut[0].read_address, 0);
    check("midrst_write_address", g_dut[0].write_address, 0);
    check("midrst_write_data",    g_dut[0].write_data, 0);
    check("midrst_write_enable",  g_dut[0].write_enable, 0);
    check("midrst_busy",          g_dut[0].busy, 0);
    check("midrst_done",          g_dut[0].done, 0);
    tick(2);
    #2;
    rst_n = 1'b1;
    w0 = g_dut[0].n_writes;
    tick(4);
    check("post_reset_no_writes", g_dut[0].n_writes - w0, 0);
    pulse(0);
    tick(22);
    check("post_reset_pass_writes", g_dut[0].n_writes - w0, 16);
    check("post_reset_queue_empty", g_dut[0].exp_q.size(), 0);

    // Latency variants, 8x8 image
    pat = PAT_MIX;
    w1 = g_dut[1].n_writes;
    w2 = g_dut[2].n_writes;
    en[1] = 1'b1;
    en[2] = 1'b1;
    tick(1);
    en[1] = 1'b0;
    en[2] = 1'b0;
    tick(75);
    check("rl1_writes", g_dut[1].n_writes - w1, 64);
    check("rl3_writes", g_dut[2].n_writes - w2, 64);
    check("rl1_queue_empty", g_dut[1].exp_q.size(), 0);
    check("rl3_queue_empty", g_dut[2].exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
